// File: rtl/ex_result_stage_if.sv
// Handshake and data bundle between the ALU, the execute result stage and writeback.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's view.
interface ex_result_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
);
    logic              valid_in;
    logic              ready_out;
    logic [DATA_W-1:0] result_in;
    logic              n_flag_in;
    logic              z_flag_in;
    logic              c_flag_in;
    logic              v_flag_in;
    logic [3:0]        cond_in;
    logic              set_flags_in;
    logic              wr_en_in;
    logic [REG_W-1:0]  rd_addr_in;
    logic              flush_in;
    logic              valid_out;
    logic              ready_in;
    logic [DATA_W-1:0] result_out;
    logic [REG_W-1:0]  rd_addr_out;
    logic              wr_en_out;
    logic              executed_out;
    logic [3:0]        nzcv_out;

    modport slave (
        input  valid_in, result_in, n_flag_in, z_flag_in, c_flag_in, v_flag_in,
        input  cond_in, set_flags_in, wr_en_in, rd_addr_in, flush_in, ready_in,
        output ready_out, valid_out, result_out, rd_addr_out, wr_en_out,
        output executed_out, nzcv_out
    );

    modport master (
        output valid_in, result_in, n_flag_in, z_flag_in, c_flag_in, v_flag_in,
        output cond_in, set_flags_in, wr_en_in, rd_addr_in, flush_in, ready_in,
        input  ready_out, valid_out, result_out, rd_addr_out, wr_en_out,
        input  executed_out, nzcv_out
    );
endinterface

// File: rtl/ex_result_stage.sv
// Execute result stage: 2-entry skid buffer for ALU results, ARM condition evaluation
// against the committed CPSR flags, and flag commit for executed S-bit instructions.
module ex_result_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input logic              clk_in,
    input logic              reset_n_in,
    ex_result_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd_addr;
        logic              wr_en;
        logic              executed;
    } entry_t;

    entry_t     head_q;
    entry_t     tail_q;
    entry_t     new_entry;
    logic [1:0] count_q;
    logic [3:0] nzcv_q;
    logic       cond_pass;
    logic       accept;
    logic       pop;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign flag_n = nzcv_q[3];
    assign flag_z = nzcv_q[2];
    assign flag_c = nzcv_q[1];
    assign flag_v = nzcv_q[0];

    // Condition is judged against the committed flags, i.e. before this instruction's own update.
    always_comb begin
        cond_pass = 1'b0;
        case (bus.cond_in)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        new_entry          = '0;
        new_entry.result   = bus.result_in;
        new_entry.rd_addr  = bus.rd_addr_in;
        new_entry.wr_en    = bus.wr_en_in;
        new_entry.executed = cond_pass;
    end

    assign bus.ready_out = (count_q < 2'd2);
    assign bus.valid_out = (count_q != 2'd0);
    assign accept        = bus.valid_in && bus.ready_out && !bus.flush_in;
    assign pop           = bus.valid_out && bus.ready_in && !bus.flush_in;

    // head_q is always the oldest entry; tail_q only holds data while two entries are buffered.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            nzcv_q  <= 4'b0000;
        end else begin
            if (accept && cond_pass && bus.set_flags_in) begin
                nzcv_q <= {bus.n_flag_in, bus.z_flag_in, bus.c_flag_in, bus.v_flag_in};
            end
            if (bus.flush_in) begin
                count_q         <= 2'd0;
                head_q.wr_en    <= 1'b0;
                head_q.executed <= 1'b0;
                tail_q.wr_en    <= 1'b0;
                tail_q.executed <= 1'b0;
            end else begin
                count_q <= count_q + 2'(accept) - 2'(pop);
                if (pop) begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                    end else if (accept) begin
                        head_q <= new_entry;
                    end
                end else if (accept) begin
                    if (count_q == 2'd0) begin
                        head_q <= new_entry;
                    end else begin
                        tail_q <= new_entry;
                    end
                end
            end
        end
    end

    assign bus.result_out   = head_q.result;
    assign bus.rd_addr_out  = head_q.rd_addr;
    assign bus.wr_en_out    = head_q.wr_en && head_q.executed;
    assign bus.executed_out = head_q.executed;
    assign bus.nzcv_out     = nzcv_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: reset, condition table sweeps, flag dependency,
// backpressure, streaming, flush and mid-transfer reset, with hand-computed expectations.
module tb_ex_result_stage;

    logic clk;
    logic reset_n;
    int   vectorCount;
    int   missCount;

    ex_result_stage_if #(.DATA_W(32), .REG_W(4)) bus ();

    ex_result_stage #(.DATA_W(32), .REG_W(4)) dut (
        .clk_in     (clk),
        .reset_n_in (reset_n),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] result,
                                 input logic [3:0] flags, input logic [3:0] cond,
                                 input logic setFlags, input logic wrEn,
                                 input logic [3:0] rd);
        bus.valid_in     = valid;
        bus.result_in    = result;
        bus.n_flag_in    = flags[3];
        bus.z_flag_in    = flags[2];
        bus.c_flag_in    = flags[1];
        bus.v_flag_in    = flags[0];
        bus.cond_in      = cond;
        bus.set_flags_in = setFlags;
        bus.wr_en_in     = wrEn;
        bus.rd_addr_in   = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Commit nzcvSet, then stream all 16 conditions (S=0) and compare against the pass mask.
    task automatic sweepConditions(input logic [3:0] nzcvSet, input logic [15:0] passMask);
        applyStimulus(1'b1, 32'h0, nzcvSet, 4'hE, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("sweep_nzcv_set", 32'(bus.nzcv_out), 32'(nzcvSet));
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, 32'h100 + 32'(c), 4'b1111, 4'(c), 1'b0, 1'b1, 4'(c));
            tick();
            checkOutput($sformatf("sweep_%h_exec_c%0d", nzcvSet, c),
                        32'(bus.executed_out), 32'(passMask[c]));
            checkOutput($sformatf("sweep_%h_res_c%0d", nzcvSet, c),
                        bus.result_out, 32'h100 + 32'(c));
        end
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("sweep_nzcv_kept", 32'(bus.nzcv_out), 32'(nzcvSet));
        checkOutput("sweep_drained", 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        vectorCount  = 0;
        missCount    = 0;
        reset_n      = 1'b0;
        bus.ready_in = 1'b1;
        bus.flush_in = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        #1;
        checkOutput("rst_valid_out", 32'(bus.valid_out), 32'd0);
        checkOutput("rst_ready_out", 32'(bus.ready_out), 32'd1);
        checkOutput("rst_result", bus.result_out, 32'd0);
        checkOutput("rst_rd_addr", 32'(bus.rd_addr_out), 32'd0);
        checkOutput("rst_wr_en", 32'(bus.wr_en_out), 32'd0);
        checkOutput("rst_executed", 32'(bus.executed_out), 32'd0);
        checkOutput("rst_nzcv", 32'(bus.nzcv_out), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] single accept");
        applyStimulus(1'b1, 32'h0000_00FF, 4'b0010, 4'hE, 1'b1, 1'b1, 4'd3);
        tick();
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        checkOutput("t1_valid_out", 32'(bus.valid_out), 32'd1);
        checkOutput("t1_result", bus.result_out, 32'h0000_00FF);
        checkOutput("t1_rd_addr", 32'(bus.rd_addr_out), 32'd3);
        checkOutput("t1_wr_en", 32'(bus.wr_en_out), 32'd1);
        checkOutput("t1_executed", 32'(bus.executed_out), 32'd1);
        checkOutput("t1_nzcv", 32'(bus.nzcv_out), 32'b0010);
        tick();
        checkOutput("t1_drained", 32'(bus.valid_out), 32'd0);

        $display("[TB] condition fail");
        applyStimulus(1'b1, 32'h10, 4'b0100, 4'hE, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("t2_nzcv_pre", 32'(bus.nzcv_out), 32'b0100);
        applyStimulus(1'b1, 32'h11, 4'b1000, 4'h1, 1'b1, 1'b1, 4'd5);
        tick();
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        checkOutput("t2_result", bus.result_out, 32'h11);
        checkOutput("t2_executed", 32'(bus.executed_out), 32'd0);
        checkOutput("t2_wr_en", 32'(bus.wr_en_out), 32'd0);
        checkOutput("t2_nzcv_kept", 32'(bus.nzcv_out), 32'b0100);
        tick();

        $display("[TB] back-to-back flag dependency");
        applyStimulus(1'b1, 32'h20, 4'b0000, 4'hE, 1'b1, 1'b0, 4'd0);
        tick();
        checkOutput("t3_nzcv_clear", 32'(bus.nzcv_out), 32'b0000);
        applyStimulus(1'b1, 32'h21, 4'b0100, 4'hE, 1'b1, 1'b0, 4'd1);
        tick();
        applyStimulus(1'b1, 32'h22, 4'b0000, 4'h0, 1'b0, 1'b1, 4'd2);
        tick();
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        checkOutput("t3_result", bus.result_out, 32'h22);
        checkOutput("t3_executed", 32'(bus.executed_out), 32'd1);
        checkOutput("t3_wr_en", 32'(bus.wr_en_out), 32'd1);
        checkOutput("t3_nzcv", 32'(bus.nzcv_out), 32'b0100);
        tick();

        $display("[TB] condition code sweeps");
        sweepConditions(4'b0100, 16'h66A9);
        sweepConditions(4'b1011, 16'h5556);
        sweepConditions(4'b1000, 16'h6A9A);

        $display("[TB] backpressure");
        bus.ready_in = 1'b0;
        applyStimulus(1'b1, 32'hA1, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd1);
        tick();
        checkOutput("t4_ready_after1", 32'(bus.ready_out), 32'd1);
        applyStimulus(1'b1, 32'hA2, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd2);
        tick();
        checkOutput("t4_ready_full", 32'(bus.ready_out), 32'd0);
        checkOutput("t4_head_a1", bus.result_out, 32'hA1);
        applyStimulus(1'b1, 32'hA3, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd3);
        tick();
        checkOutput("t4_ready_still_full", 32'(bus.ready_out), 32'd0);
        checkOutput("t4_head_stable", bus.result_out, 32'hA1);
        checkOutput("t4_rd_stable", 32'(bus.rd_addr_out), 32'd1);
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        bus.ready_in = 1'b1;
        tick();
        checkOutput("t4_drain_a2", bus.result_out, 32'hA2);
        checkOutput("t4_drain_valid", 32'(bus.valid_out), 32'd1);
        checkOutput("t4_drain_ready", 32'(bus.ready_out), 32'd1);
        tick();
        checkOutput("t4_drained", 32'(bus.valid_out), 32'd0);

        $display("[TB] simultaneous accept and pop");
        applyStimulus(1'b1, 32'hB0, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 32'hB0 + 32'(i), 4'b0000, 4'hE, 1'b0, 1'b1, 4'(i));
            tick();
            checkOutput($sformatf("t5_result_%0d", i), bus.result_out, 32'hB0 + 32'(i));
            checkOutput($sformatf("t5_ready_%0d", i), 32'(bus.ready_out), 32'd1);
            checkOutput($sformatf("t5_valid_%0d", i), 32'(bus.valid_out), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("t5_drained", 32'(bus.valid_out), 32'd0);

        $display("[TB] flush");
        bus.ready_in = 1'b0;
        applyStimulus(1'b1, 32'hC1, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd1);
        tick();
        applyStimulus(1'b1, 32'hC2, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd2);
        tick();
        checkOutput("t6_full", 32'(bus.ready_out), 32'd0);
        applyStimulus(1'b1, 32'hC3, 4'b0101, 4'hE, 1'b1, 1'b1, 4'd3);
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        checkOutput("t6_valid_out", 32'(bus.valid_out), 32'd0);
        checkOutput("t6_ready_out", 32'(bus.ready_out), 32'd1);
        checkOutput("t6_nzcv", 32'(bus.nzcv_out), 32'b1000);
        tick();
        checkOutput("t6_not_captured", 32'(bus.valid_out), 32'd0);
        applyStimulus(1'b1, 32'hC4, 4'b0000, 4'hE, 1'b0, 1'b1, 4'd4);
        tick();
        checkOutput("t6b_one_entry", bus.result_out, 32'hC4);
        applyStimulus(1'b1, 32'hC5, 4'b0101, 4'hE, 1'b1, 1'b1, 4'd5);
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        checkOutput("t6b_valid_out", 32'(bus.valid_out), 32'd0);
        checkOutput("t6b_nzcv", 32'(bus.nzcv_out), 32'b1000);
        bus.ready_in = 1'b1;
        tick();
        checkOutput("t6b_not_captured", 32'(bus.valid_out), 32'd0);

        $display("[TB] reset mid-transfer");
        bus.ready_in = 1'b0;
        applyStimulus(1'b1, 32'hD1, 4'b1111, 4'hE, 1'b1, 1'b1, 4'd7);
        tick();
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'hE, 1'b0, 1'b0, 4'd0);
        checkOutput("t7_nzcv_set", 32'(bus.nzcv_out), 32'b1111);
        checkOutput("t7_valid_pre", 32'(bus.valid_out), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t7_valid_async", 32'(bus.valid_out), 32'd0);
        checkOutput("t7_nzcv_async", 32'(bus.nzcv_out), 32'd0);
        checkOutput("t7_result_async", bus.result_out, 32'd0);
        checkOutput("t7_ready_async", 32'(bus.ready_out), 32'd1);
        tick();
        reset_n = 1'b1;
        bus.ready_in = 1'b1;
        tick();
        checkOutput("t7_idle_after", 32'(bus.valid_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-to-writeback stage placed directly downstream of the ALU. It captures the ALU result and its N/Z/C/V flags into a 2-entry skid buffer with a valid/ready handshake. It evaluates the instruction's 4-bit ARM condition code against the committed CPSR flags and commits new flags when the instruction executes with its S bit set. Register-file writes are suppressed for instructions whose condition fails.

## Interface
Parameters:
- DATA_W, 32, width of result path
- REG_W, 4, width of destination register address

Ports:
- clk_in  input  1  rising-edge clock
- reset_n_in  input  1  asynchronous, active-low reset
- valid_in  input  1  upstream holds a valid ALU result this cycle
- ready_out  output  1  stage can accept; equals (count < 2)
- result_in  input  DATA_W  ALU result
- n_flag_in, z_flag_in, c_flag_in, v_flag_in  input  1 each  ALU flags
- cond_in  input  4  ARM condition field of the instruction
- set_flags_in  input  1  S bit: commit flags if executed
- wr_en_in  input  1  instruction writes a destination register
- rd_addr_in  input  REG_W  destination register
- flush_in  input  1  discard all buffered entries
- valid_out  output  1  head entry valid
- ready_in  input  1  downstream accepts head entry
- result_out  output  DATA_W  head result
- rd_addr_out  output  REG_W  head destination
- wr_en_out  output  1  head wr_en AND head executed
- executed_out  output  1  head entry passed its condition
- nzcv_out  output  4  committed CPSR flags {N,Z,C,V}

## Operation
- Accept occurs when valid_in & ready_out & ~flush_in.
- Pop occurs when valid_out & ready_in & ~flush_in.
- Condition pass is combinational from cond_in and the current nzcv register, which holds the pre-update value:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F never (0)
- On accept, the stage stores {result, rd_addr, wr_en, pass} in the FIFO tail.
- Flags commit: if accept & pass & set_flags_in, nzcv is loaded from {n,z,c,v}_flag_in at the same edge.
  - Failed or non-S instructions leave nzcv unchanged.
- Buffer: 2 entries, in-order. count takes values 0..2.
  - Accept only → count+1.
  - Pop only → count−1.
  - Accept and pop together (count=1) → count unchanged; the new entry becomes the head at the next edge.
- Flush: count becomes 0 at the next edge and both entries are invalidated. No accept occurs that cycle. nzcv is not rolled back.
- The head outputs hold stable while valid_out & ~ready_in.

## Timing
- Reset (asynchronous, immediate on reset_n_in low):
  - count=0, valid_out=0, ready_out=1
  - result_out=0, rd_addr_out=0, wr_en_out=0, executed_out=0
  - nzcv_out=4'b0000
- Latency is 1 cycle: an entry accepted at edge t appears on valid_out/result_out after edge t.
- Sustained throughput is 1 per cycle while ready_in stays high.
- A flag update from an instruction accepted at edge t is visible to the condition of the instruction presented in cycle t+1, so back-to-back flag-dependent conditions resolve correctly.
- ready_out derives from registered count only. There is no combinational path from ready_in to ready_out.
- If reset asserts mid-transfer, the in-flight entry is lost and nzcv returns to 0.

## Test plan
- Reset then single accept:
  - Stimulus: result 0x0000_00FF, cond E, S=1, flags N0Z0C1V0, rd 3, wr_en 1.
  - Response: one cycle later valid_out=1, result_out=0xFF, rd_addr_out=3, wr_en_out=1, executed_out=1, nzcv_out=0010.
- Condition fail:
  - Stimulus: nzcv=0100, instruction cond 1 (NE), S=1, flags 1000.
  - Response: executed_out=0, wr_en_out=0, nzcv_out stays 0100.
- Back-to-back dependency:
  - Stimulus: first instruction cond E, S=1, Z=1; next cycle, instruction cond 0 (EQ).
  - Response: the second instruction has executed_out=1.
- Backpressure:
  - Stimulus: ready_in=0 while 3 valid entries are offered.
  - Response: first 2 accepted, ready_out=0 afterwards, head stable. Raising ready_in drains the entries in order with 1 per cycle.
- Simultaneous accept+pop at count=1 for 10 cycles:
  - Response: count stays 1, ready_out stays 1, outputs are the in-order sequence.
- Flush with count=2 and valid_in=1:
  - Response: the next cycle has valid_out=0, ready_out=1, the flushed-cycle input is not captured, and nzcv is unchanged.
